dmem_responder: RTL and testbench

Data-memory responder for the CPU's load/store port: it accepts one word-aligned read or write request at a time and holds it for a programmable number of wait cycles. It then returns a response through a valid/ready handshake. It sits between the core's memory-access stage and the word-organised data RAM, and replaces the zero-latency combinational data memory so that the core can be tested against realistic memory stalls.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and address check for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_LAT_MAX = 15;
  localparam int WORD_W       = 32;
  localparam int BE_W         = 4;

  // A request is in error when it is not word aligned or its word index does
  // not fit in an array of 2**aw words; upper bits never wrap into the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-enabled RAM: one synchronous write port, two asynchronous read ports
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [WORD_W-1:0] dbg_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Byte-masked write: only the enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Both read ports see the array as it stands before the current edge's write.
  assign rdata_o    = mem_q[raddr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with programmable wait cycles
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [WORD_W-1:0]              req_addr,
  input  logic [WORD_W-1:0]              req_wdata,
  input  logic [BE_W-1:0]                req_be,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WORD_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [WORD_W-1:0]              dbg_data
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         ZERO_LAT = (LATENCY == 0);
  // Counter counts down to 0 inclusive, so LATENCY wait cycles need LATENCY-1.
  localparam logic [3:0] CNT_LOAD = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;

  // Request latched at acceptance.
  logic              we_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err_q;

  logic              accept;
  logic              commit;
  logic              req_err;
  logic [AW-1:0]     req_idx;
  logic              cur_we;
  logic              cur_err;
  logic [AW-1:0]     cur_idx;
  logic [WORD_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

  assign accept  = req_valid & req_ready;
  assign req_idx = req_addr[2 +: AW];
  assign req_err = addr_err(req_addr, AW);

  // With zero latency the commit happens on the acceptance edge, so it has to
  // use the live request rather than the copy that is latched on that edge.
  assign cur_we    = ZERO_LAT ? req_we    : we_q;
  assign cur_err   = ZERO_LAT ? req_err   : err_q;
  assign cur_idx   = ZERO_LAT ? req_idx   : idx_q;
  assign cur_wdata = ZERO_LAT ? req_wdata : wdata_q;
  assign cur_be    = ZERO_LAT ? req_be    : be_q;

  // Gating with rst keeps a zero-latency store presented during reset out of the array.
  assign arr_we = commit & cur_we & ~cur_err & rst;

  // Next-state, wait counter and response data; commit marks the edge that
  // reads or writes the array and enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ZERO_LAT) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          rerr_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (commit) begin
      rdata_d = (!cur_we && !cur_err) ? arr_rdata : '0;
      rerr_d  = cur_err;
    end
  end

  // State, counter and response registers; reset abandons any pending request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Capture the request fields on acceptance for use at the commit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
      be_q    <= req_be;
      err_q   <= req_err;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk       (clk),
    .we_i      (arr_we),
    .waddr_i   (cur_idx),
    .wdata_i   (cur_wdata),
    .be_i      (cur_be),
    .raddr_i   (cur_idx),
    .rdata_o   (arr_rdata),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at latencies 2, 0 and 4
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 4;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic [9:0]  dbg_addr  [NI];
  logic [31:0] dbg_data  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    ((g == 0) ? 2 : (g == 1) ? 0 : 4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .dbg_addr (dbg_addr[g]),
      .dbg_data (dbg_data[g])
    );
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Transaction-level model: one outstanding request per instance, response
  // visible from edge acc+L, memory update at edge acc+L, handshake after that.
  bit          m_busy  [NI];
  int          m_acc   [NI];
  logic [31:0] m_rdata [NI];
  bit          m_err   [NI];
  bit          m_pend  [NI];
  int          m_pidx  [NI];
  logic [31:0] m_pdata [NI];
  logic [31:0] mmem    [NI][DEPTH];
  bit          mknown  [NI][DEPTH];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name, input int k);
    n_vec++;
    n_bad++;
    $display("FAIL %s dut%0d: timed out at cycle %0d", name, k, cyc);
  endtask

  task automatic model_accept(input int k);
    logic [31:0] a;
    logic [31:0] merged;
    int w;
    a = req_addr[k];
    m_busy[k]  = 1'b1;
    m_acc[k]   = cyc;
    m_err[k]   = (a % 4 != 0) || (a / 4 >= DEPTH);
    m_rdata[k] = 32'h0;
    w = m_err[k] ? 0 : int'(a / 4);
    if (!m_err[k] && !req_we[k]) m_rdata[k] = mmem[k][w];
    if (!m_err[k] && req_we[k]) begin
      merged = mmem[k][w];
      for (int b = 0; b < 4; b++)
        if (req_be[k][b]) merged[8*b +: 8] = req_wdata[k][8*b +: 8];
      m_pidx[k]  = w;
      m_pdata[k] = merged;
      m_pend[k]  = 1'b1;
      if (req_be[k] == 4'hF) mknown[k][w] = 1'b1;
      if (lat_of(k) == 0) begin
        mmem[k][w] = merged;
        m_pend[k]  = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < NI; k++) begin
      if (!rst[k]) begin
        m_busy[k] = 1'b0;
        m_pend[k] = 1'b0;
      end else if (m_busy[k]) begin
        if (m_pend[k] && cyc == m_acc[k] + lat_of(k)) begin
          mmem[k][m_pidx[k]] = m_pdata[k];
          m_pend[k] = 1'b0;
        end
        if (cyc > m_acc[k] + lat_of(k) && rsp_ready[k]) m_busy[k] = 1'b0;
      end else if (req_valid[k]) begin
        model_accept(k);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    bit          v;
    logic [31:0] er;
    bit          ee;
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        if (rst[k]) begin
          v  = m_busy[k] && (cyc >= m_acc[k] + lat_of(k));
          er = v ? m_rdata[k] : 32'h0;
          ee = v ? m_err[k] : 1'b0;
          check("req_ready", k, req_ready[k], !m_busy[k]);
          check("rsp_valid", k, rsp_valid[k], v);
          check("rsp_rdata", k, rsp_rdata[k], er);
          check("rsp_err",   k, rsp_err[k],   ee);
          if (mknown[k][dbg_addr[k]]) check("dbg_data", k, dbg_data[k], mmem[k][dbg_addr[k]]);
        end
      end
    end
  end

  task automatic do_req(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit wait_done,
                        output int acc, output int lat, output logic [31:0] rdata, output logic err);
    int t;
    acc = -1; lat = -1; rdata = 32'hx; err = 1'bx;
    @(negedge clk); #1;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_be[k] = be;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!m_busy[k] && t < 20);
    req_valid[k] = 1'b0;
    if (!m_busy[k]) begin
      timeout("accept", k);
      return;
    end
    acc = m_acc[k];
    t = 0;
    while (t < 40) begin
      @(negedge clk); t++;
      if (rsp_valid[k] === 1'b1) begin
        lat = cyc - acc + 1; rdata = rsp_rdata[k]; err = rsp_err[k];
        break;
      end
    end
    if (lat < 0) timeout("rsp_valid", k);
    if (wait_done) begin
      t = 0;
      while (m_busy[k] && t < 40) begin
        @(posedge clk); #1; t++;
      end
      if (m_busy[k]) timeout("handshake", k);
    end
  endtask

  task automatic dbg_check(input int k, input int idx, input logic [31:0] exp, input string name);
    @(negedge clk); #1;
    dbg_addr[k] = 10'(idx);
    @(negedge clk);
    check(name, k, dbg_data[k], exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          acc, lat, acc_prev, t;
    logic [31:0] rd;
    logic        er;
    logic [31:0] l0 [4];
    l0[0] = 32'h1111_0000; l0[1] = 32'h2222_0001; l0[2] = 32'h3333_0002; l0[3] = 32'h4444_0003;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'h0;
      req_wdata[k] = 32'h0; req_be[k] = 4'h0; rsp_ready[k] = 1'b1; dbg_addr[k] = 10'h0;
      m_busy[k] = 1'b0; m_pend[k] = 1'b0; m_acc[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset rsp_valid", k, rsp_valid[k], 32'h0);
      check("reset rsp_rdata", k, rsp_rdata[k], 32'h0);
      check("reset rsp_err",   k, rsp_err[k],   32'h0);
    end
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    for (int k = 0; k < NI; k++) check("release req_ready", k, req_ready[k], 32'h1);

    // Load after store, LATENCY=2.
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, acc, lat, rd, er);
    check("store latency", 0, lat, 3);
    check("store rdata", 0, rd, 32'h0);
    check("store err", 0, er, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc, lat, rd, er);
    check("load latency", 0, lat, 3);
    check("load rdata", 0, rd, 32'hDEADBEEF);
    check("load err", 0, er, 32'h0);

    // Byte enables.
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, acc, lat, rd, er);
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, acc, lat, rd, er);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, acc, lat, rd, er);
    check("be merge", 0, rd, 32'h11BB33DD);

    // Errors.
    do_req(0, 1'b1, 32'h0, 32'hCAFE0000, 4'hF, 1'b1, acc, lat, rd, er);
    do_req(0, 1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 1'b1, acc, lat, rd, er);
    do_req(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1, acc, lat, rd, er);
    check("misaligned err", 0, er, 32'h1);
    check("misaligned rdata", 0, rd, 32'h0);
    do_req(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1, acc, lat, rd, er);
    check("range store err", 0, er, 32'h1);
    check("range store rdata", 0, rd, 32'h0);
    do_req(0, 1'b0, 32'h1000_0010, 32'h0, 4'h0, 1'b1, acc, lat, rd, er);
    check("upper bits err", 0, er, 32'h1);
    check("upper bits rdata", 0, rd, 32'h0);
    dbg_check(0, 0,    32'hCAFE0000, "word0 intact");
    dbg_check(0, 8,    32'h11BB33DD, "word8 intact");
    dbg_check(0, 1023, 32'h5A5A5A5A, "last word intact");
    dbg_check(0, 4,    32'hDEADBEEF, "word4 intact");

    // Empty byte-enable store.
    do_req(0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1, acc, lat, rd, er);
    check("be0 err", 0, er, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc, lat, rd, er);
    check("be0 keeps word", 0, rd, 32'hDEADBEEF);

    // Backpressure with a competing request during the stall.
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, acc, lat, rd, er);
    check("bp first rdata", 0, rd, 32'hDEADBEEF);
    #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0; req_be[0] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp rsp_valid", 0, rsp_valid[0], 32'h1);
      check("bp rsp_rdata", 0, rsp_rdata[0], 32'hDEADBEEF);
      check("bp rsp_err",   0, rsp_err[0],   32'h0);
      check("bp req_ready", 0, req_ready[0], 32'h0);
    end
    #1;
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    t = 0;
    while (m_busy[0] && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (m_busy[0]) timeout("bp release", 0);
    dbg_check(0, 4, 32'hDEADBEEF, "bp request ignored");

    // Zero latency, back-to-back loads.
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b1, 32'(4 * i), l0[i], 4'hF, 1'b1, acc, lat, rd, er);
      check("l0 store latency", 1, lat, 1);
    end
    acc_prev = -1;
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b1, acc, lat, rd, er);
      check("l0 load latency", 1, lat, 1);
      check("l0 load rdata", 1, rd, l0[i]);
      if (i > 0) check("l0 accept spacing", 1, acc - acc_prev, 2);
      acc_prev = acc;
    end

    // Reset during WAIT, LATENCY=4.
    do_req(2, 1'b1, 32'h30, 32'h0, 4'hF, 1'b1, acc, lat, rd, er);
    check("l4 store latency", 2, lat, 5);
    dbg_addr[2] = 10'd12;
    @(negedge clk); #1;
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h30; req_wdata[2] = 32'h12345678; req_be[2] = 4'hF;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("l4 waiting req_ready", 2, req_ready[2], 32'h0);
    @(negedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    check("in reset rsp_valid", 2, rsp_valid[2], 32'h0);
    #1;
    rst[2] = 1'b1;
    @(negedge clk);
    check("post reset req_ready", 2, req_ready[2], 32'h1);
    check("post reset rsp_valid", 2, rsp_valid[2], 32'h0);
    repeat (4) @(negedge clk);
    check("discarded store", 2, dbg_data[2], 32'h0);
    do_req(2, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, acc, lat, rd, er);
    check("l4 load latency", 2, lat, 5);
    check("l4 load rdata", 2, rd, 32'h0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
